// File: rtl/ex_operand_stage_if.sv
// Decode/hazard/bypass to EX operand-stage bundle.
// master: the upstream pipeline driving the stage; slave: ex_operand_stage.
interface ex_operand_stage_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned RW  = 5,
    parameter int unsigned OPW = 4
);
    logic           id_valid;
    logic [OPW-1:0] id_aluop;
    logic [DW-1:0]  id_rdat1;
    logic [DW-1:0]  id_rdat2;
    logic [DW-1:0]  id_imm;
    logic [4:0]     id_shamt;
    logic [1:0]     id_alusrc;
    logic [RW-1:0]  id_rs;
    logic [RW-1:0]  id_rt;
    logic [RW-1:0]  id_wsel;
    logic           id_regwen;
    logic           stall;
    logic           flush;
    logic           exmem_regwen;
    logic [RW-1:0]  exmem_wsel;
    logic [DW-1:0]  exmem_result;
    logic           memwb_regwen;
    logic [RW-1:0]  memwb_wsel;
    logic [DW-1:0]  memwb_wdat;
    logic           ex_valid;
    logic [OPW-1:0] ALUOP;
    logic [DW-1:0]  Port_A;
    logic [DW-1:0]  Port_B;
    logic [DW-1:0]  ex_store_dat;
    logic [RW-1:0]  ex_wsel;
    logic           ex_regwen;

    modport master (
        output id_valid, id_aluop, id_rdat1, id_rdat2, id_imm, id_shamt,
               id_alusrc, id_rs, id_rt, id_wsel, id_regwen, stall, flush,
               exmem_regwen, exmem_wsel, exmem_result,
               memwb_regwen, memwb_wsel, memwb_wdat,
        input  ex_valid, ALUOP, Port_A, Port_B, ex_store_dat, ex_wsel, ex_regwen
    );

    modport slave (
        input  id_valid, id_aluop, id_rdat1, id_rdat2, id_imm, id_shamt,
               id_alusrc, id_rs, id_rt, id_wsel, id_regwen, stall, flush,
               exmem_regwen, exmem_wsel, exmem_result,
               memwb_regwen, memwb_wsel, memwb_wdat,
        output ex_valid, ALUOP, Port_A, Port_B, ex_store_dat, ex_wsel, ex_regwen
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with result forwarding and ALU operand select.
// Define EX_FORWARD_EN to enable EX/MEM + MEM/WB bypass and stall refresh.
module ex_operand_stage #(
    parameter int unsigned DW  = 32,
    parameter int unsigned RW  = 5,
    parameter int unsigned OPW = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    ex_operand_stage_if.slave bus
);
    localparam int unsigned SHW = 5;

    typedef struct packed {
        logic           valid;
        logic [OPW-1:0] aluop;
        logic [DW-1:0]  rdat1;
        logic [DW-1:0]  rdat2;
        logic [DW-1:0]  imm;
        logic [SHW-1:0] shamt;
        logic [1:0]     alusrc;
        logic [RW-1:0]  rs;
        logic [RW-1:0]  rt;
        logic [RW-1:0]  wsel;
        logic           regwen;
    } ex_fields_t;

    ex_fields_t    ex_q;
    ex_fields_t    ex_d;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

`ifdef EX_FORWARD_EN
    // EX/MEM wins over MEM/WB; register 0 never takes a bypass value.
    function automatic logic [DW-1:0] fwd_sel(input logic [RW-1:0] src,
                                              input logic [DW-1:0] latched);
        logic [DW-1:0] r;
        r = latched;
        if (src != '0) begin
            if (bus.exmem_regwen && (bus.exmem_wsel == src))
                r = bus.exmem_result;
            else if (bus.memwb_regwen && (bus.memwb_wsel == src))
                r = bus.memwb_wdat;
        end
        return r;
    endfunction

    always_comb begin
        fwd_rs = fwd_sel(ex_q.rs, ex_q.rdat1);
        fwd_rt = fwd_sel(ex_q.rt, ex_q.rdat2);
    end
`else
    always_comb begin
        fwd_rs = ex_q.rdat1;
        fwd_rt = ex_q.rdat2;
    end

    // Bypass ports and source numbers are kept for interface stability only.
    logic unused_bypass;
    assign unused_bypass = ^{bus.exmem_regwen, bus.exmem_wsel, bus.exmem_result,
                             bus.memwb_regwen, bus.memwb_wsel, bus.memwb_wdat,
                             ex_q.rs, ex_q.rt};
`endif

    // Next-state: flush > stall > load.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.stall) begin
`ifdef EX_FORWARD_EN
            // Refresh so a producer retiring during the stall is not lost.
            ex_d.rdat1 = fwd_rs;
            ex_d.rdat2 = fwd_rt;
`endif
        end else begin
            ex_d.valid  = bus.id_valid;
            ex_d.aluop  = bus.id_aluop;
            ex_d.rdat1  = bus.id_rdat1;
            ex_d.rdat2  = bus.id_rdat2;
            ex_d.imm    = bus.id_imm;
            ex_d.shamt  = bus.id_shamt;
            ex_d.alusrc = bus.id_alusrc;
            ex_d.rs     = bus.id_rs;
            ex_d.rt     = bus.id_rt;
            ex_d.wsel   = bus.id_wsel;
            ex_d.regwen = bus.id_regwen;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    // Operand select and pipe control outputs.
    always_comb begin
        bus.Port_A = fwd_rs;
        bus.Port_B = fwd_rt;
        case (ex_q.alusrc)
            2'b01: bus.Port_B = ex_q.imm;
            2'b10: begin
                bus.Port_A = fwd_rt;
                bus.Port_B = DW'(ex_q.shamt);
            end
            default: ;
        endcase
        bus.ex_store_dat = fwd_rt;
        bus.ex_valid     = ex_q.valid;
        bus.ALUOP        = ex_q.aluop;
        bus.ex_wsel      = ex_q.wsel;
        bus.ex_regwen    = ex_q.regwen & ex_q.valid;
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage (either EX_FORWARD_EN build).
module tb_ex_operand_stage;
    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_fail;

    ex_operand_stage_if bif ();

    ex_operand_stage dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] imm,
                          input logic [4:0] sh, input logic [1:0] src,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] ws, input logic we);
        bif.id_valid  = v;
        bif.id_aluop  = op;
        bif.id_rdat1  = r1;
        bif.id_rdat2  = r2;
        bif.id_imm    = imm;
        bif.id_shamt  = sh;
        bif.id_alusrc = src;
        bif.id_rs     = rs;
        bif.id_rt     = rt;
        bif.id_wsel   = ws;
        bif.id_regwen = we;
    endtask

    task automatic bypass(input logic ew, input logic [4:0] es, input logic [31:0] ed,
                          input logic mw, input logic [4:0] ms, input logic [31:0] md);
        bif.exmem_regwen = ew;
        bif.exmem_wsel   = es;
        bif.exmem_result = ed;
        bif.memwb_regwen = mw;
        bif.memwb_wsel   = ms;
        bif.memwb_wdat   = md;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(bif.ex_valid), 32'h0);
        check({tag, "_aluop"}, 32'(bif.ALUOP), 32'h0);
        check({tag, "_porta"}, bif.Port_A, 32'h0);
        check({tag, "_portb"}, bif.Port_B, 32'h0);
        check({tag, "_store"}, bif.ex_store_dat, 32'h0);
        check({tag, "_wsel"}, 32'(bif.ex_wsel), 32'h0);
        check({tag, "_regwen"}, 32'(bif.ex_regwen), 32'h0);
    endtask

    initial begin
        logic fwd_on;
`ifdef EX_FORWARD_EN
        fwd_on = 1'b1;
`else
        fwd_on = 1'b0;
`endif
        n_checks = 0;
        n_fail   = 0;
        nRST     = 1'b0;
        bif.stall = 1'b0;
        bif.flush = 1'b0;
        set_id(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        check_zero("reset");
        tick();
        tick();
        nRST = 1'b1;

        // Plain load, one-cycle latency.
        set_id(1'b1, 4'h2, 32'h10, 32'h20, 32'h100, 5'd4, 2'b00, 5'd4, 5'd7, 5'd3, 1'b1);
        check("pre_load_porta", bif.Port_A, 32'h0);
        tick();
        check("load_porta", bif.Port_A, 32'h10);
        check("load_portb", bif.Port_B, 32'h20);
        check("load_wsel", 32'(bif.ex_wsel), 32'h3);
        check("load_regwen", 32'(bif.ex_regwen), 32'h1);
        check("load_valid", 32'(bif.ex_valid), 32'h1);
        check("load_aluop", 32'(bif.ALUOP), 32'h2);
        check("load_store", bif.ex_store_dat, 32'h20);

        // Forwarding priority on latched rs=4.
        bypass(1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
        #1;
        check("fwd_exmem", bif.Port_A, fwd_on ? 32'hAAAA : 32'h10);
        bif.exmem_regwen = 1'b0;
        #1;
        check("fwd_memwb", bif.Port_A, fwd_on ? 32'hBBBB : 32'h10);
        check("fwd_rt_untouched", bif.Port_B, 32'h20);

        // Register 0 never forwarded.
        set_id(1'b1, 4'h2, 32'h10, 32'h20, 32'h100, 5'd4, 2'b00, 5'd0, 5'd7, 5'd3, 1'b1);
        tick();
        bypass(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
        #1;
        check("fwd_r0", bif.Port_A, 32'h10);

        // Stall refresh on rt=7.
        bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 4'h2, 32'h10, 32'h20, 32'h100, 5'd4, 2'b00, 5'd4, 5'd7, 5'd3, 1'b1);
        tick();
        bif.stall = 1'b1;
        set_id(1'b1, 4'h5, 32'h99, 32'h98, 32'h97, 5'd9, 2'b01, 5'd9, 5'd9, 5'd9, 1'b0);
        bypass(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
        #1;
        check("stall_fwd_portb", bif.Port_B, fwd_on ? 32'h1234 : 32'h20);
        tick();
        bif.memwb_regwen = 1'b0;
        #1;
        check("stall_refresh_portb", bif.Port_B, fwd_on ? 32'h1234 : 32'h20);
        check("stall_refresh_store", bif.ex_store_dat, fwd_on ? 32'h1234 : 32'h20);
        tick();
        check("stall_hold_wsel", 32'(bif.ex_wsel), 32'h3);
        check("stall_hold_aluop", 32'(bif.ALUOP), 32'h2);
        check("stall_hold_porta", bif.Port_A, 32'h10);
        bif.stall = 1'b0;

        // Shift select: Port_A = rt value, Port_B = shamt.
        set_id(1'b1, 4'h0, 32'h77, 32'h1, 32'h100, 5'd4, 2'b10, 5'd4, 5'd7, 5'd8, 1'b1);
        tick();
        check("shift_porta", bif.Port_A, 32'h1);
        check("shift_portb", bif.Port_B, 32'h4);
        check("shift_aluop", 32'(bif.ALUOP), 32'h0);

        // Immediate select and alusrc=11 aliasing reg/reg.
        set_id(1'b1, 4'h3, 32'h55, 32'h66, 32'hDEADBEEF, 5'd31, 2'b01, 5'd1, 5'd2, 5'd8, 1'b1);
        tick();
        check("imm_porta", bif.Port_A, 32'h55);
        check("imm_portb", bif.Port_B, 32'hDEADBEEF);
        check("imm_store", bif.ex_store_dat, 32'h66);
        set_id(1'b1, 4'h3, 32'h55, 32'h66, 32'hDEADBEEF, 5'd31, 2'b11, 5'd1, 5'd2, 5'd8, 1'b1);
        tick();
        check("src11_porta", bif.Port_A, 32'h55);
        check("src11_portb", bif.Port_B, 32'h66);

        // Flush wins over stall.
        bif.stall = 1'b1;
        bif.flush = 1'b1;
        tick();
        check_zero("flush");
        bif.stall = 1'b0;
        bif.flush = 1'b0;

        // Invalid slot gates regwen.
        set_id(1'b0, 4'h2, 32'h11, 32'h22, 32'h0, 5'd0, 2'b00, 5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        check("inv_regwen", 32'(bif.ex_regwen), 32'h0);
        check("inv_wsel", 32'(bif.ex_wsel), 32'h6);
        check("inv_porta", bif.Port_A, 32'h11);

        // Asynchronous reset mid-operation.
        set_id(1'b1, 4'h2, 32'h5, 32'h6, 32'h0, 5'd0, 2'b00, 5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        check("prerst_porta", bif.Port_A, 32'h5);
        #2;
        nRST = 1'b0;
        #1;
        check_zero("async_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage that sits directly upstream of the execute-stage ALU.
- Captures decoded operands and control from decode, then applies EX/MEM and MEM/WB result forwarding.
- Drives the ALU's ALUOP, Port_A and Port_B plus the destination-register control carried down the pipe.
- Handles the pipeline stall (hold) and flush (bubble) requests from the hazard unit.

Parameters:
- DW, 32, datapath width; also the width of Port_A and Port_B.
- RW, 5, register-select width.
- OPW, 4, ALU opcode width; matches aluop_t in cpu_types_pkg.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_aluop  in  OPW  ALU operation from decode.
- id_rdat1  in  DW  register-file rs value.
- id_rdat2  in  DW  register-file rt value.
- id_imm  in  DW  extended immediate.
- id_shamt  in  5  shift amount.
- id_alusrc  in  2  operand select: 00 reg/reg, 01 reg/imm, 10 shift (rt,shamt), 11 same as 00.
- id_rs, id_rt, id_wsel  in  RW  source and destination register numbers.
- id_regwen  in  1  instruction writes the register file.
- stall  in  1  hold the current EX contents.
- flush  in  1  replace the EX contents with a bubble.
- exmem_regwen, exmem_wsel, exmem_result  in  1/RW/DW  EX/MEM bypass source.
- memwb_regwen, memwb_wsel, memwb_wdat  in  1/RW/DW  MEM/WB bypass source.
- ex_valid  out  1  EX slot holds a real instruction.
- ALUOP  out  OPW  to ALU.
- Port_A, Port_B  out  DW  to ALU.
- ex_store_dat  out  DW  forwarded rt value, used for sw.
- ex_wsel  out  RW  destination register.
- ex_regwen  out  1  destination write enable; gated by ex_valid.

Behaviour:
- Reset (nRST low, async): all latched fields clear to 0, so every output reads 0 and ALUOP=0 (ALU_SLL, harmless with zero operands).
- Update on the CLK rising edge. Priority is flush > stall > load.
  - Load: capture all id_* fields. Latency from decode to ALU inputs is 1 cycle.
  - Flush: ex_valid=0, ex_regwen=0, ALUOP=0, operands and registers=0. Flush asserted together with stall yields a bubble.
  - Stall: hold all control fields. The latched rs/rt data fields are rewritten with their currently forwarded values (refresh), so a producer that retires during the stall is not lost.
- Forwarding is combinational from the latched fields and the bypass inputs, per source S in {rs, rt}:
  - fwd(S) = exmem_result if exmem_regwen and exmem_wsel==S and S!=0;
  - otherwise memwb_wdat if memwb_regwen and memwb_wsel==S and S!=0;
  - otherwise the latched data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand mux:
  - alusrc 00/11: Port_A=fwd(rs), Port_B=fwd(rt).
  - alusrc 01: Port_A=fwd(rs), Port_B=imm.
  - alusrc 10: Port_A=fwd(rt), Port_B={27'b0,shamt}.
- ex_store_dat=fwd(rt) always.
- ex_regwen = latched regwen AND ex_valid. When invalid, operands are still driven but carry no architectural effect.
- No internal arithmetic; widths pass through unchanged. The shamt zero-extension is the only width change.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding, stall refresh and the bypass ports are active as above.
- Undefined: fwd(S) = latched data; the stall holds data unchanged; the exmem_*/memwb_* inputs are ignored (ports kept for a stable interface). The hazard unit must then stall through writeback.

Test Plan:
- Reset mid-operation: load id_rdat1=0x5, assert nRST low between edges -> all outputs 0 immediately, without waiting for an edge.
- Load: id_valid=1, id_aluop=ADD, rdat1=0x10, rdat2=0x20, alusrc=00, wsel=3, regwen=1 -> next cycle Port_A=0x10, Port_B=0x20, ex_wsel=3, ex_regwen=1.
- Forward priority: latched rs=4, exmem {1,4,0xAAAA}, memwb {1,4,0xBBBB} -> Port_A=0xAAAA. Drop exmem_regwen -> Port_A=0xBBBB. Set rs=0 -> latched value.
- Stall refresh: stall=1, memwb {1,rt=7,0x1234} for one cycle, then memwb_regwen=0 -> Port_B stays 0x1234 while stalled.
- Shift select: alusrc=10, rt value 0x1, shamt=4, ALU_SLL -> Port_A=0x1, Port_B=0x4.
- Flush with stall: stall=1, flush=1 -> ex_valid=0, ex_regwen=0, ALUOP=0. With EX_FORWARD_EN undefined, the forward scenario yields the latched value.
